// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects
// and the branch-flush state machine states.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        FL_IDLE,
        FL_FLUSH
    } flush_state_t;

endpackage

// File: rtl/hazard_sb.sv
// Register scoreboard for long-latency writebacks, plus the ID-stage
// dependency check (RAW on both sources, WAW on the destination).
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int RA_W = 5,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            lt_issue,
    input  logic [RA_W-1:0] lt_rd,
    input  logic            lt_done,
    input  logic [RA_W-1:0] lt_done_rd,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic            id_regwrite,
    output logic [NREG-1:0] busy,
    output logic            sb_stall
);

    logic [NREG-1:0] busy_next;

    // Issue is applied after done so a same-cycle set/clear keeps the new owner.
    always_comb begin
        busy_next = busy;
        if (lt_done)
            busy_next[lt_done_rd] = 1'b0;
        if (lt_issue)
            busy_next[lt_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            busy <= '0;
        else
            busy <= busy_next;
    end

    assign sb_stall = (busy[id_rs1] && id_rs1_used)
                   || (busy[id_rs2] && id_rs2_used)
                   || (busy[id_rd]  && id_regwrite);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: operand forwarding, load-use and
// scoreboard stalls, branch-mispredict flush and a stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int RA_W         = 5,
    parameter int NREG         = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_regwrite,
    input  logic [RA_W-1:0]  ex_rs1,
    input  logic [RA_W-1:0]  ex_rs2,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic             mem_regwrite,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic             wb_regwrite,
    input  logic             lt_issue,
    input  logic [RA_W-1:0]  lt_rd,
    input  logic             lt_done,
    input  logic [RA_W-1:0]  lt_done_rd,
    input  logic             br_mispredict,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall_if_id,
    output logic             bubble_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [NREG-1:0]  sb_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    flush_state_t state;
    logic [2:0]   flush_cnt;
    logic         load_use;
    logic         sb_stall;
    logic         flushing;
    logic         stall;

    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
        if (mem_regwrite && mem_rd != '0 && mem_rd == rs)
            return FWD_MEM;
        else if (wb_regwrite && wb_rd != '0 && wb_rd == rs)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign fwd_a = fwd_sel(ex_rs1);
    assign fwd_b = fwd_sel(ex_rs2);

    assign load_use = ex_memread && ex_regwrite && ex_rd != '0
                   && ((id_rs1_used && id_rs1 == ex_rd)
                    || (id_rs2_used && id_rs2 == ex_rd));

    hazard_sb #(
        .RA_W (RA_W),
        .NREG (NREG)
    ) u_sb (
        .clk         (clk),
        .reset_n     (reset_n),
        .lt_issue    (lt_issue),
        .lt_rd       (lt_rd),
        .lt_done     (lt_done),
        .lt_done_rd  (lt_done_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_regwrite (id_regwrite),
        .busy        (sb_busy),
        .sb_stall    (sb_stall)
    );

    assign flushing    = br_mispredict || (state == FL_FLUSH);
    assign flush_if_id = flushing;
    assign flush_id_ex = flushing;
    assign stall       = (load_use || sb_stall) && !flushing;
    assign stall_if_id = stall;
    assign bubble_ex   = stall;

    // flush_cnt holds the flush cycles still owed after the current one, so the
    // mispredict cycle itself counts toward FLUSH_CYCLES.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= FL_IDLE;
            flush_cnt <= '0;
        end else if (br_mispredict) begin
            flush_cnt <= FLUSH_LOAD;
            state     <= (FLUSH_LOAD == 3'd0) ? FL_IDLE : FL_FLUSH;
        end else if (state == FL_FLUSH) begin
            if (flush_cnt <= 3'd1) begin
                flush_cnt <= '0;
                state     <= FL_IDLE;
            end else begin
                flush_cnt <= flush_cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (stall && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a vector table for the combinational
// forwarding/load-use logic plus directed multi-cycle sequences.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset_n;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used, id_regwrite;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_regwrite, ex_memread;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        lt_issue;
    logic [4:0]  lt_rd;
    logic        lt_done;
    logic [4:0]  lt_done_rd;
    logic        br_mispredict;
    logic [1:0]  fwd_a, fwd_b;
    logic        stall_if_id, bubble_ex, flush_if_id, flush_id_ex;
    logic [31:0] sb_busy;
    logic [31:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    hazard_ctrl #(
        .RA_W         (5),
        .NREG         (32),
        .FLUSH_CYCLES (3),
        .CNT_W        (32)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .id_regwrite   (id_regwrite),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_rd         (ex_rd),
        .ex_regwrite   (ex_regwrite),
        .ex_memread    (ex_memread),
        .mem_rd        (mem_rd),
        .mem_regwrite  (mem_regwrite),
        .wb_rd         (wb_rd),
        .wb_regwrite   (wb_regwrite),
        .lt_issue      (lt_issue),
        .lt_rd         (lt_rd),
        .lt_done       (lt_done),
        .lt_done_rd    (lt_done_rd),
        .br_mispredict (br_mispredict),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .stall_if_id   (stall_if_id),
        .bubble_ex     (bubble_ex),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .sb_busy       (sb_busy),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] mem_rd;
        logic       mem_rw;
        logic [4:0] wb_rd;
        logic       wb_rw;
        logic [4:0] ex_rd;
        logic       ex_rw;
        logic       ex_memread;
        logic [4:0] id_rs1;
        logic       id_rs1_used;
        logic [4:0] id_rs2;
        logic       id_rs2_used;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_regwrite = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
        ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = '0; mem_regwrite = 1'b0;
        wb_rd = '0; wb_regwrite = 1'b0;
        lt_issue = 1'b0; lt_rd = '0; lt_done = 1'b0; lt_done_rd = '0;
        br_mispredict = 1'b0;
    endtask

    // Inputs change 1 time unit after a rising edge; checks follow 2 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        clear_inputs();
        ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2;
        mem_rd = v.mem_rd; mem_regwrite = v.mem_rw;
        wb_rd = v.wb_rd; wb_regwrite = v.wb_rw;
        ex_rd = v.ex_rd; ex_regwrite = v.ex_rw; ex_memread = v.ex_memread;
        id_rs1 = v.id_rs1; id_rs1_used = v.id_rs1_used;
        id_rs2 = v.id_rs2; id_rs2_used = v.id_rs2_used;
        #2;
    endtask

    task automatic check_output(input vec_t v);
        check({v.name, ".fwd_a"}, 32'(fwd_a), 32'(v.exp_a));
        check({v.name, ".fwd_b"}, 32'(fwd_b), 32'(v.exp_b));
        check({v.name, ".stall"}, 32'(stall_if_id), 32'(v.exp_stall));
        check({v.name, ".bubble"}, 32'(bubble_ex), 32'(v.exp_stall));
    endtask

    initial begin
        // name, ex_rs1, ex_rs2, mem_rd, mem_rw, wb_rd, wb_rw, ex_rd, ex_rw, ex_memread,
        // id_rs1, id_rs1_used, id_rs2, id_rs2_used, exp_a, exp_b, exp_stall
        vecs[0]  = '{"dbl_fwd",     5, 0, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0};
        vecs[1]  = '{"wb_only",     5, 0, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0};
        vecs[2]  = '{"x0_never",    0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0};
        vecs[3]  = '{"split",       4, 6, 6, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0};
        vecs[4]  = '{"wb_rw_off",   4, 6, 6, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0};
        vecs[5]  = '{"lu_rs2",      0, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 7, 1, 2'b00, 2'b00, 1};
        vecs[6]  = '{"lu_unused",   0, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 7, 0, 2'b00, 2'b00, 0};
        vecs[7]  = '{"lu_rs1",      0, 0, 0, 0, 0, 0, 7, 1, 1, 7, 1, 0, 0, 2'b00, 2'b00, 1};
        vecs[8]  = '{"lu_x0",       0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0};
        vecs[9]  = '{"no_memread",  0, 0, 0, 0, 0, 0, 7, 1, 0, 7, 1, 0, 0, 2'b00, 2'b00, 0};
        vecs[10] = '{"no_regwr",    0, 0, 0, 0, 0, 0, 7, 0, 1, 7, 1, 0, 0, 2'b00, 2'b00, 0};
        vecs[11] = '{"mem_ne_wb_eq",3, 3, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0};

        clear_inputs();
        reset_n = 1'b0;
        #2;
        check("rst.sb_busy", sb_busy, 32'h0);
        check("rst.stall_cnt", stall_cnt, 32'h0);
        check("rst.flush", 32'(flush_if_id), 32'h0);
        check("rst.stall", 32'(stall_if_id), 32'h0);
        next_cycle();
        reset_n = 1'b1;
        #1;

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i]);
            next_cycle();
        end

        // Load-use: one stall cycle, then the consumer forwards from MEM/WB.
        do_reset();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7;
        id_rs2 = 5'd7; id_rs2_used = 1'b1;
        #2;
        check("lu_seq.stall", 32'(stall_if_id), 32'h1);
        next_cycle();
        clear_inputs();
        ex_rs2 = 5'd7; wb_rd = 5'd7; wb_regwrite = 1'b1;
        #2;
        check("lu_seq.fwd_b", 32'(fwd_b), 32'h1);
        check("lu_seq.stall_after", 32'(stall_if_id), 32'h0);
        check("lu_seq.stall_cnt", stall_cnt, 32'd1);

        // Scoreboard: issue x9, dependent ID stalls until the cycle after done.
        do_reset();
        lt_issue = 1'b1; lt_rd = 5'd9;
        id_rs1 = 5'd9; id_rs1_used = 1'b1;
        #2;
        check("sb.cyc0_stall", 32'(stall_if_id), 32'h0);
        next_cycle();
        lt_issue = 1'b0;
        #2;
        check("sb.cyc1_busy", sb_busy, 32'h0000_0200);
        for (int c = 1; c < 12; c++) begin
            if (stall_if_id !== 1'b1)
                check($sformatf("sb.cyc%0d_stall", c), 32'(stall_if_id), 32'h1);
            next_cycle();
        end
        lt_done = 1'b1; lt_done_rd = 5'd9;
        #2;
        check("sb.cyc12_stall", 32'(stall_if_id), 32'h1);
        next_cycle();
        lt_done = 1'b0;
        #2;
        check("sb.cyc13_stall", 32'(stall_if_id), 32'h0);
        check("sb.cyc13_busy", sb_busy, 32'h0);
        check("sb.stall_cnt", stall_cnt, 32'd12);
        id_rs1_used = 1'b0;
        lt_issue = 1'b1; lt_rd = 5'd0;
        next_cycle();
        lt_issue = 1'b0;
        #2;
        check("sb.x0_busy", sb_busy, 32'h0);

        // WAW check through id_rd, then same-cycle set and clear of x3.
        lt_issue = 1'b1; lt_rd = 5'd3;
        next_cycle();
        lt_issue = 1'b0;
        id_rd = 5'd3; id_regwrite = 1'b1;
        #2;
        check("sb.waw_stall", 32'(stall_if_id), 32'h1);
        id_regwrite = 1'b0;
        lt_issue = 1'b1; lt_rd = 5'd3; lt_done = 1'b1; lt_done_rd = 5'd3;
        next_cycle();
        lt_issue = 1'b0; lt_done = 1'b0;
        #2;
        check("sb.setclr_busy", sb_busy, 32'h0000_0008);
        lt_done = 1'b1; lt_done_rd = 5'd3;
        next_cycle();
        lt_done = 1'b0;
        #2;
        check("sb.clr_busy", sb_busy, 32'h0);

        // Flush: mispredicts at cycles 0 and 2 with FLUSH_CYCLES=3, load-use held.
        do_reset();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7;
        id_rs1 = 5'd7; id_rs1_used = 1'b1;
        for (int c = 0; c < 6; c++) begin
            br_mispredict = (c == 0 || c == 2);
            #2;
            check($sformatf("fl.cyc%0d_flush_if_id", c), 32'(flush_if_id), (c < 5) ? 32'h1 : 32'h0);
            check($sformatf("fl.cyc%0d_flush_id_ex", c), 32'(flush_id_ex), (c < 5) ? 32'h1 : 32'h0);
            check($sformatf("fl.cyc%0d_stall", c), 32'(stall_if_id), (c < 5) ? 32'h0 : 32'h1);
            next_cycle();
        end
        check("fl.stall_cnt", stall_cnt, 32'd1);

        // Async reset mid-flush with x9 pending and 40 counted stall cycles.
        do_reset();
        lt_issue = 1'b1; lt_rd = 5'd9;
        id_rs1 = 5'd9; id_rs1_used = 1'b1;
        next_cycle();
        lt_issue = 1'b0;
        for (int c = 0; c < 40; c++)
            next_cycle();
        id_rs1_used = 1'b0;
        #2;
        check("ar.pre_cnt", stall_cnt, 32'd40);
        check("ar.pre_busy", sb_busy, 32'h0000_0200);
        br_mispredict = 1'b1;
        next_cycle();
        br_mispredict = 1'b0;
        #2;
        check("ar.mid_flush", 32'(flush_if_id), 32'h1);
        reset_n = 1'b0;
        #1;
        check("ar.flush", 32'(flush_if_id), 32'h0);
        check("ar.busy", sb_busy, 32'h0);
        check("ar.cnt", stall_cnt, 32'h0);
        #2;
        reset_n = 1'b1;
        next_cycle();
        #2;
        check("ar.post_flush", 32'(flush_id_ex), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage in-order core. Sits beside the ID/EX/MEM/WB pipeline registers. It produces operand forwarding selects, load-use stalls and branch-mispredict flushes. A register scoreboard tracks long-latency (multi-cycle mul/div) writebacks, and a counter accumulates stall cycles for performance monitoring.

## Interface
Parameters:
- RA_W, 5, register address width.
- NREG, 32, architectural register count (2**RA_W).
- FLUSH_CYCLES, 1, cycles flush outputs are held after a mispredict (1..7).
- CNT_W, 32, stall counter width.

Ports (all inputs are synchronous to clk):
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2, id_rd  in  RA_W  operand and destination registers of the instruction in ID.
- id_rs1_used, id_rs2_used, id_regwrite  in  1  validity of the above.
- ex_rs1, ex_rs2  in  RA_W  operands of the instruction in EX.
- ex_rd  in  RA_W, ex_regwrite  in  1, ex_memread  in  1  describe the instruction in EX.
- mem_rd  in  RA_W, mem_regwrite  in  1  describe EX/MEM.
- wb_rd  in  RA_W, wb_regwrite  in  1  describe MEM/WB.
- lt_issue  in  1, lt_rd  in  RA_W  mean a long-latency op leaves EX with destination lt_rd.
- lt_done  in  1, lt_done_rd  in  RA_W  mean the long-latency op writes back lt_done_rd.
- br_mispredict  in  1  single-cycle mispredict pulse from EX.
- fwd_a, fwd_b  out  2  forwarding select for ex_rs1 / ex_rs2.
- stall_if_id  out  1  hold the PC and IF/ID register.
- bubble_ex  out  1  insert a NOP into ID/EX.
- flush_if_id, flush_id_ex  out  1  squash the wrong-path instructions.
- sb_busy  out  NREG  scoreboard pending-write bits.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
- **Forwarding** (combinational):
  - fwd_a = 2'b10 if mem_regwrite && mem_rd!=0 && mem_rd==ex_rs1.
  - Otherwise 2'b01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs1.
  - Otherwise 2'b00.
  - fwd_b is computed the same way from ex_rs2.
  - EX/MEM always has priority over MEM/WB. Register x0 is never forwarded.
- **Load-use**: lu = ex_memread && ex_regwrite && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)).
- **Scoreboard** (registered), per bit r:
  - Set when lt_issue && lt_rd==r && r!=0.
  - Cleared when lt_done && lt_done_rd==r.
  - Set and clear of the same r in one cycle resolves to set (new owner). Bit 0 is constant 0.
- **Scoreboard stall**: sb = sb_busy[id_rs1]&&id_rs1_used, OR sb_busy[id_rs2]&&id_rs2_used, OR sb_busy[id_rd]&&id_regwrite. The id_rd term prevents WAW.
- **Stall outputs**: stall_if_id = bubble_ex = (lu || sb) && !flushing.
- **Flush FSM**, states IDLE and FLUSH, 3-bit counter:
  - IDLE→FLUSH on br_mispredict, counter loaded with FLUSH_CYCLES-1.
  - In FLUSH the counter decrements each cycle. FLUSH→IDLE when the counter is 0 and br_mispredict=0.
  - A br_mispredict in FLUSH reloads the counter.
  - flush_if_id = flush_id_ex = br_mispredict || (state==FLUSH).
  - flushing = the same expression. Flush overrides stall.
- **Flush and scoreboard**: flush does not touch the scoreboard. Ops already past EX are committed.
- **Stall counter**: stall_cnt increments each cycle stall_if_id=1. It saturates at all-ones.

## Timing
- Reset values: FSM=IDLE, counter=0, sb_busy=0, stall_cnt=0. Therefore fwd_*, stall and flush outputs follow their combinational inputs and show no state-driven assertion.
- Forwarding, stall and flush have zero-cycle latency from their inputs.
- sb_busy updates on the clock edge. A dependent ID instruction stalls from the cycle after lt_issue. The stall releases in the cycle after lt_done.
- A load-use stall lasts exactly 1 cycle. The load then sits in MEM/WB and the consumer gets fwd=01.
- With FLUSH_CYCLES=N, flush outputs are high for N cycles starting with the mispredict cycle.
- Reset asserted mid-flush or with pending scoreboard bits clears everything immediately (asynchronous).

## Structure
- **Package hazard_pkg**: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, and the flush state enum {FL_IDLE, FL_FLUSH}.
- **Sub-module hazard_sb**: the NREG-bit scoreboard, covering set/clear logic and the read mux for the three ID ports.
- **hazard_ctrl**: forwarding, load-use, flush FSM and stall counter.

## Test plan
- **Double forward**: mem_rd=5, wb_rd=5 (both regwrite), ex_rs1=5, ex_rs2=0 → fwd_a=10, fwd_b=00. Repeat with mem_regwrite=0 → fwd_a=01.
- **Load-use**: ex_memread=1, ex_rd=7, id_rs2=7 used → stall_if_id=bubble_ex=1 for 1 cycle, stall_cnt=1. Next cycle wb_rd=7 → fwd_b=01.
- **Scoreboard**:
  - lt_issue rd=9 at cycle 0 → sb_busy[9]=1 from cycle 1.
  - ID reading x9 stalls until lt_done rd=9 at cycle 12 → stall drops at cycle 13, stall_cnt=12.
  - lt_issue rd=0 → sb_busy stays 0.
- **Simultaneous set/clear**: lt_done rd=3 and lt_issue rd=3 in the same cycle → sb_busy[3] stays 1.
- **Flush**: FLUSH_CYCLES=3, mispredict at cycle 0 and again at cycle 2 → flush high for cycles 0-4. A load-use condition during that window → stall=0.
- **Async reset**: reset_n low mid-FLUSH with sb_busy=0x0000_0200 and stall_cnt=40 → all cleared without waiting for a clock edge.
